// File: rtl/niosii_led_sequencer_if.sv
// Avalon-MM slave bus bundle for niosii_led_sequencer: word address, select,
// active-low write strobe and zero-latency read data.
interface niosii_led_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/niosii_led_sequencer.sv
// Avalon-MM LED sequencer: static DATA value when idle, or steps through up to
// four PATTERN entries at PERIOD cycles per step. Optional irq via NIOSII_LED_SEQ_IRQ_EN.
module niosii_led_sequencer #(
  parameter int unsigned PERIOD_W    = 16,
  parameter logic [7:0]  RESET_VALUE = 8'h55
) (
  input  logic                    clk,
  input  logic                    reset,
  niosii_led_sequencer_if.slave   avs,
  output logic [7:0]              out_port
`ifdef NIOSII_LED_SEQ_IRQ_EN
  ,
  output logic                    irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           data_q, data_d;
  logic                 run_q, run_d;
  logic                 oneshot_q, oneshot_d;
  logic                 done_q, done_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [1:0]           length_q, length_d;
  logic [7:0]           pattern_q [4];
  logic [7:0]           pattern_d [4];
  logic [1:0]           idx_q, idx_d;
  logic [PERIOD_W-1:0]  presc_q, presc_d;
  logic [7:0]           out_q, out_d;
  logic                 irq_bit;

`ifdef NIOSII_LED_SEQ_IRQ_EN
  logic                 irq_en_q, irq_en_d;
  assign irq_bit = irq_en_q;
  assign irq     = done_q && irq_en_q;
`else
  assign irq_bit = 1'b0;
`endif

  logic                 wr_en;
  logic                 wr_ctrl;
  logic                 start;
  logic [PERIOD_W-1:0]  wr_period;
  logic                 unused_wd;

  assign wr_en     = avs.chipselect && !avs.write_n;
  assign wr_ctrl   = wr_en && (avs.address == 3'd1);
  assign start     = wr_ctrl && avs.writedata[0];
  assign wr_period = avs.writedata[PERIOD_W-1:0];
  assign unused_wd = ^avs.writedata;

  assign out_port = out_q;

  // Register file next-state
  always_comb begin
    data_d    = data_q;
    period_d  = period_q;
    length_d  = length_q;
    run_d     = run_q;
    oneshot_d = oneshot_q;
    done_d    = done_q;
`ifdef NIOSII_LED_SEQ_IRQ_EN
    irq_en_d  = irq_en_q;
`endif
    for (int unsigned i = 0; i < 4; i++) begin
      pattern_d[i] = pattern_q[i];
    end

    if (wr_en) begin
      case (avs.address)
        3'd0: data_d = avs.writedata[7:0];
        3'd1: begin
          run_d     = avs.writedata[0];
          oneshot_d = avs.writedata[1];
          done_d    = 1'b0;
`ifdef NIOSII_LED_SEQ_IRQ_EN
          irq_en_d  = avs.writedata[4];
`endif
        end
        3'd2: period_d = (wr_period == '0) ? PERIOD_W'(1) : wr_period;
        3'd3: length_d = avs.writedata[1:0];
        default: pattern_d[avs.address[1:0]] = avs.writedata[7:0];
      endcase
    end

    // Sequence completion overrides the RUN/DONE bits; it never coincides
    // with a CONTROL write because that write takes priority in the FSM.
    if (state_q == S_RUN && !wr_ctrl && presc_q == '0 &&
        idx_q >= length_q && oneshot_q) begin
      run_d  = 1'b0;
      done_d = 1'b1;
    end
  end

  // Sequencer FSM next-state; boundary decisions use pre-write register values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    out_d   = out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        out_d = data_d;
        if (wr_ctrl) begin
          if (start) begin
            state_d = S_RUN;
            idx_d   = 2'd0;
            presc_d = period_q - PERIOD_W'(1);
            out_d   = pattern_q[0];
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (start) begin
          idx_d   = 2'd0;
          presc_d = period_q - PERIOD_W'(1);
          out_d   = pattern_q[0];
        end else if (wr_ctrl) begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          out_d   = data_d;
        end else if (presc_q != '0) begin
          presc_d = presc_q - PERIOD_W'(1);
        end else if (idx_q < length_q) begin
          idx_d   = idx_q + 2'd1;
          presc_d = period_q - PERIOD_W'(1);
          out_d   = pattern_q[idx_q + 2'd1];
        end else if (!oneshot_q) begin
          idx_d   = 2'd0;
          presc_d = period_q - PERIOD_W'(1);
          out_d   = pattern_q[0];
        end else begin
          state_d = S_DONE;
          idx_d   = 2'd0;
          out_d   = data_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
        out_d   = data_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= RESET_VALUE;
      run_q     <= 1'b0;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
      period_q  <= PERIOD_W'(1);
      length_q  <= 2'd3;
      idx_q     <= 2'd0;
      presc_q   <= '0;
      out_q     <= RESET_VALUE;
`ifdef NIOSII_LED_SEQ_IRQ_EN
      irq_en_q  <= 1'b0;
`endif
      for (int unsigned i = 0; i < 4; i++) begin
        pattern_q[i] <= '0;
      end
    end else begin
      data_q    <= data_d;
      run_q     <= run_d;
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
      period_q  <= period_d;
      length_q  <= length_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      out_q     <= out_d;
`ifdef NIOSII_LED_SEQ_IRQ_EN
      irq_en_q  <= irq_en_d;
`endif
      for (int unsigned i = 0; i < 4; i++) begin
        pattern_q[i] <= pattern_d[i];
      end
    end
  end

  // Zero-latency, side-effect-free read mux
  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      3'd0:    avs.readdata = {24'd0, data_q};
      3'd1:    avs.readdata = {27'd0, irq_bit, done_q, (state_q == S_RUN),
                               oneshot_q, run_q};
      3'd2:    avs.readdata = 32'(period_q);
      3'd3:    avs.readdata = {30'd0, length_q};
      default: avs.readdata = {24'd0, pattern_q[avs.address[1:0]]};
    endcase
  end

endmodule

// File: tb/tb_niosii_led_sequencer.sv
// Directed bench for niosii_led_sequencer: register table plus hand-timed
// sequences for stepping, one-shot, stop/restart and mid-run register writes.
module tb_niosii_led_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] out_port;
`ifdef NIOSII_LED_SEQ_IRQ_EN
  logic       irq;
`endif

  niosii_led_sequencer_if bus ();

  niosii_led_sequencer #(
    .PERIOD_W    (16),
    .RESET_VALUE (8'h55)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .avs      (bus),
    .out_port (out_port)
`ifdef NIOSII_LED_SEQ_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t       vt[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] pat [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(name, bus.readdata, exp);
  endtask

  function automatic void add(input string n, input logic [2:0] a, input logic w,
                              input logic [31:0] d, input logic [31:0] er,
                              input logic [7:0] eo);
    vec_t v;
    v.name = n; v.addr = a; v.wr = w; v.wdata = d; v.exp_rd = er; v.exp_out = eo;
    vt.push_back(v);
  endfunction

  initial begin
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;

    add("rst_data",    3'd0, 1'b0, 32'h0,     32'h55,   8'h55);
    add("rst_ctrl",    3'd1, 1'b0, 32'h0,     32'h0,    8'h55);
    add("rst_period",  3'd2, 1'b0, 32'h0,     32'h1,    8'h55);
    add("rst_length",  3'd3, 1'b0, 32'h0,     32'h3,    8'h55);
    add("rst_pat0",    3'd4, 1'b0, 32'h0,     32'h0,    8'h55);
    add("rst_pat1",    3'd5, 1'b0, 32'h0,     32'h0,    8'h55);
    add("rst_pat2",    3'd6, 1'b0, 32'h0,     32'h0,    8'h55);
    add("rst_pat3",    3'd7, 1'b0, 32'h0,     32'h0,    8'h55);
    add("wr_data_a5",  3'd0, 1'b1, 32'hA5,    32'hA5,   8'hA5);
    add("wr_data_hi",  3'd0, 1'b1, 32'h1FF3C, 32'h3C,   8'h3C);
    add("wr_period0",  3'd2, 1'b1, 32'h0,     32'h1,    8'h3C);
    add("wr_period_w", 3'd2, 1'b1, 32'h12345, 32'h2345, 8'h3C);
    add("wr_length",   3'd3, 1'b1, 32'hFE,    32'h2,    8'h3C);
    add("wr_pat0",     3'd4, 1'b1, 32'h101,   32'h01,   8'h3C);
    add("wr_pat1",     3'd5, 1'b1, 32'h02,    32'h02,   8'h3C);
    add("wr_pat2",     3'd6, 1'b1, 32'h04,    32'h04,   8'h3C);
    add("wr_pat3",     3'd7, 1'b1, 32'h108,   32'h08,   8'h3C);
`ifdef NIOSII_LED_SEQ_IRQ_EN
    add("wr_ctrl_ie",  3'd1, 1'b1, 32'h10,    32'h10,   8'h3C);
`else
    add("wr_ctrl_ie",  3'd1, 1'b1, 32'h10,    32'h0,    8'h3C);
`endif
    add("wr_ctrl_os",  3'd1, 1'b1, 32'h02,    32'h02,   8'h3C);
    add("wr_ctrl_0",   3'd1, 1'b1, 32'h00,    32'h00,   8'h3C);
    add("wr_length3",  3'd3, 1'b1, 32'h3,     32'h3,    8'h3C);
    add("wr_period3",  3'd2, 1'b1, 32'h3,     32'h3,    8'h3C);
    add("wr_data_55",  3'd0, 1'b1, 32'h55,    32'h55,   8'h55);
    add("re_pat0",     3'd4, 1'b0, 32'h0,     32'h01,   8'h55);

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    reset = 1'b1;
    steps(3);
    reset = 1'b0;

    foreach (vt[i]) begin
      bus.address    = vt[i].addr;
      bus.chipselect = 1'b1;
      bus.write_n    = !vt[i].wr;
      bus.writedata  = vt[i].wdata;
      step();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      #1;
      chk({vt[i].name, "_rd"},  bus.readdata, vt[i].exp_rd);
      chk({vt[i].name, "_out"}, {24'd0, out_port}, {24'd0, vt[i].exp_out});
    end

    // Looping run, PERIOD=3, four steps
    wr(3'd1, 32'h1);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) step();
      chk($sformatf("loop_k%0d", k), {24'd0, out_port}, {24'd0, pat[(k / 3) % 4]});
      if (k == 4) rd_chk("loop_busy", 3'd1, 32'h5);
    end
    wr(3'd1, 32'h0);
    chk("stop_out", {24'd0, out_port}, 32'h55);
    rd_chk("stop_ctrl", 3'd1, 32'h0);

    // One-shot run ends in DONE showing DATA
    wr(3'd1, 32'h3);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) step();
      chk($sformatf("os_k%0d", k), {24'd0, out_port},
          (k < 12) ? {24'd0, pat[k / 3]} : 32'h55);
    end
    bus.address = 3'd1;
    #1;
    chk("os_done_ctrl", bus.readdata & 32'hD, 32'h8);
    wr(3'd0, 32'h99);
    chk("done_data_follow", {24'd0, out_port}, 32'h99);
    wr(3'd1, 32'h0);
    rd_chk("done_clear", 3'd1, 32'h0);
    wr(3'd0, 32'h55);

    // Stop mid step 2, then 1-cycle steps from PERIOD=0
    wr(3'd1, 32'h1);
    steps(7);
    wr(3'd1, 32'h0);
    chk("midstop_out", {24'd0, out_port}, 32'h55);
    rd_chk("midstop_busy", 3'd1, 32'h0);
    wr(3'd2, 32'h0);
    rd_chk("period0_rd", 3'd2, 32'h1);
    wr(3'd1, 32'h1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      chk($sformatf("p1_k%0d", k), {24'd0, out_port}, {24'd0, pat[k % 4]});
    end
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h3);

    // PATTERN write during step 0, LENGTH shrink while on index 3
    wr(3'd1, 32'h1);
    chk("pw_k0", {24'd0, out_port}, 32'h01);
    wr(3'd5, 32'h20);
    chk("pw_k1", {24'd0, out_port}, 32'h01);
    step();
    chk("pw_k2", {24'd0, out_port}, 32'h01);
    step();
    chk("pw_k3", {24'd0, out_port}, 32'h20);
    steps(6);
    chk("ln_k9", {24'd0, out_port}, 32'h08);
    wr(3'd3, 32'h1);
    chk("ln_k10", {24'd0, out_port}, 32'h08);
    step();
    chk("ln_k11", {24'd0, out_port}, 32'h08);
    step();
    chk("ln_k12_wrap", {24'd0, out_port}, 32'h01);
    steps(3);
    chk("ln_k15", {24'd0, out_port}, 32'h20);
    steps(3);
    chk("ln_k18_wrap", {24'd0, out_port}, 32'h01);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h3);
    wr(3'd5, 32'h2);

    // PERIOD write landing on a step boundary: reload uses old PERIOD
    wr(3'd1, 32'h1);
    steps(2);
    wr(3'd2, 32'h5);
    chk("pb_k3", {24'd0, out_port}, 32'h02);
    steps(2);
    chk("pb_k5", {24'd0, out_port}, 32'h02);
    step();
    chk("pb_k6", {24'd0, out_port}, 32'h04);
    steps(4);
    chk("pb_k10", {24'd0, out_port}, 32'h04);
    step();
    chk("pb_k11", {24'd0, out_port}, 32'h08);
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h3);

    // RUN=1 while running restarts at index 0
    wr(3'd1, 32'h1);
    steps(4);
    wr(3'd1, 32'h1);
    chk("rs_k0", {24'd0, out_port}, 32'h01);
    steps(2);
    chk("rs_k2", {24'd0, out_port}, 32'h01);
    step();
    chk("rs_k3", {24'd0, out_port}, 32'h02);
    wr(3'd1, 32'h0);

`ifdef NIOSII_LED_SEQ_IRQ_EN
    wr(3'd1, 32'h13);
    steps(11);
    chk("irq_k11", {31'd0, irq}, 32'h0);
    step();
    chk("irq_k12", {31'd0, irq}, 32'h1);
    wr(3'd1, 32'h10);
    chk("irq_clear", {31'd0, irq}, 32'h0);
    rd_chk("irq_ctrl", 3'd1, 32'h10);
`endif

    // Reset mid-run
    wr(3'd1, 32'h1);
    steps(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_out", {24'd0, out_port}, 32'h55);
    rd_chk("mrst_period", 3'd2, 32'h1);
    step();
    rd_chk("mrst_ctrl", 3'd1, 32'h0);
    rd_chk("mrst_pat0", 3'd4, 32'h0);
    step();
    chk("mrst_hold", {24'd0, out_port}, 32'h55);
`ifdef NIOSII_LED_SEQ_IRQ_EN
    chk("mrst_irq", {31'd0, irq}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
